// File: rtl/mode7_scanline_engine_if.sv
// Signal bundle between vga_sync/config host/texture ROM (master) and the Mode7 engine (slave).
interface mode7_scanline_engine_if #(
  parameter int COORD_W = 10,
  parameter int MAT_W   = 16,
  parameter int TEX_LG  = 6,
  parameter int COLOR_W = 8
);
  logic                  pixel_tick;
  logic                  video_on;
  logic [COORD_W-1:0]    pixel_x;
  logic [COORD_W-1:0]    pixel_y;
  logic                  frame_start;
  logic                  cfg_we;
  logic [2:0]            cfg_addr;
  logic [MAT_W-1:0]      cfg_wdata;
  logic [2*TEX_LG-1:0]   tex_addr;
  logic [COLOR_W-1:0]    tex_data;
  logic [COLOR_W-1:0]    rgb;
  logic                  rgb_valid;
  logic                  setup_busy;

  modport master (
    output pixel_tick, video_on, pixel_x, pixel_y, frame_start,
    output cfg_we, cfg_addr, cfg_wdata, tex_data,
    input  tex_addr, rgb, rgb_valid, setup_busy
  );

  modport slave (
    input  pixel_tick, video_on, pixel_x, pixel_y, frame_start,
    input  cfg_we, cfg_addr, cfg_wdata, tex_data,
    output tex_addr, rgb, rgb_valid, setup_busy
  );
endinterface

// File: rtl/mode7_scanline_engine.sv
// Mode7 affine texture mapper: per-line setup on one shared multiplier, per-pixel u/v stepping.
// Optional MODE7_CLAMP_EN: out-of-texture texels show BACKDROP instead of wrapping.
module mode7_scanline_engine #(
  parameter int COORD_W  = 10,
  parameter int FRAC_W   = 8,
  parameter int MAT_W    = 16,
  parameter int TEX_LG   = 6,
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter logic [COLOR_W-1:0] BACKDROP = '0
) (
  input  logic clk,
  input  logic reset,
  mode7_scanline_engine_if.slave bus
);
  localparam int ACC_W = MAT_W + COORD_W + 2;
  localparam int DW    = COORD_W + 1;
  localparam logic [MAT_W-1:0] ONE = MAT_W'(1) << FRAC_W;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL_A = 3'd1;
  localparam logic [2:0] MUL_B = 3'd2;
  localparam logic [2:0] MUL_C = 3'd3;
  localparam logic [2:0] MUL_D = 3'd4;
  localparam logic [2:0] LOAD  = 3'd5;

  // Register map order: A B C D H V X0 Y0; A and D come up as 1.0.
  logic [7:0][MAT_W-1:0] cfg_rst_val;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cfg_rst
      assign cfg_rst_val[gi] = (gi == 0 || gi == 3) ? ONE : '0;
    end
  endgenerate

  logic [MAT_W-1:0] shadow_reg [8];
  logic [MAT_W-1:0] active_reg [8];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_reg[i] <= cfg_rst_val[i];
        active_reg[i] <= cfg_rst_val[i];
      end
    end else begin
      if (bus.frame_start) begin
        for (int i = 0; i < 8; i++) active_reg[i] <= shadow_reg[i];
      end
      if (bus.cfg_we) shadow_reg[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  logic [MAT_W-1:0]   a_q, b_q, c_q, d_q;
  logic [COORD_W-1:0] h_q, v_q, x0_q, y0_q;
  assign a_q  = active_reg[0];
  assign b_q  = active_reg[1];
  assign c_q  = active_reg[2];
  assign d_q  = active_reg[3];
  assign h_q  = active_reg[4][COORD_W-1:0];
  assign v_q  = active_reg[5][COORD_W-1:0];
  assign x0_q = active_reg[6][COORD_W-1:0];
  assign y0_q = active_reg[7][COORD_W-1:0];

  logic [2:0]         state_reg;
  logic [COORD_W-1:0] line_y_reg;
  logic [ACC_W-1:0]   u_part_reg, v_part_reg;
  logic [ACC_W-1:0]   u_acc_reg, v_acc_reg;

  logic [DW-1:0] dx, dy;
  assign dx = {h_q[COORD_W-1], h_q} - {x0_q[COORD_W-1], x0_q};
  assign dy = {1'b0, line_y_reg} + {v_q[COORD_W-1], v_q} - {y0_q[COORD_W-1], y0_q};

  // Single multiplier, operands steered by the setup state.
  logic [MAT_W-1:0] mul_coef;
  logic [DW-1:0]    mul_op;
  logic [ACC_W-1:0] mul_prod;
  always_comb begin
    mul_coef = a_q;
    mul_op   = dx;
    case (state_reg)
      MUL_B:   begin mul_coef = b_q; mul_op = dy; end
      MUL_C:   begin mul_coef = c_q; mul_op = dx; end
      MUL_D:   begin mul_coef = d_q; mul_op = dy; end
      default: ;
    endcase
  end
  assign mul_prod = {{(ACC_W-MAT_W){mul_coef[MAT_W-1]}}, mul_coef}
                  * {{(ACC_W-DW){mul_op[DW-1]}}, mul_op};

  logic [ACC_W-1:0] x0_fix, y0_fix, a_ext, c_ext;
  assign x0_fix = {{(ACC_W-COORD_W-FRAC_W){x0_q[COORD_W-1]}}, x0_q, {FRAC_W{1'b0}}};
  assign y0_fix = {{(ACC_W-COORD_W-FRAC_W){y0_q[COORD_W-1]}}, y0_q, {FRAC_W{1'b0}}};
  assign a_ext  = {{(ACC_W-MAT_W){a_q[MAT_W-1]}}, a_q};
  assign c_ext  = {{(ACC_W-MAT_W){c_q[MAT_W-1]}}, c_q};

  logic line_trig, restart, step;
  assign line_trig = bus.pixel_tick && (bus.pixel_x == COORD_W'(H_ACTIVE))
                  && (bus.pixel_y < COORD_W'(V_ACTIVE - 1));
  assign restart   = bus.frame_start || line_trig;
  assign step      = bus.pixel_tick && bus.video_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      line_y_reg <= '0;
      u_part_reg <= '0;
      v_part_reg <= '0;
    end else if (bus.frame_start) begin
      state_reg  <= MUL_A;
      line_y_reg <= '0;
    end else if (line_trig) begin
      state_reg  <= MUL_A;
      line_y_reg <= bus.pixel_y + 1'b1;
    end else begin
      case (state_reg)
        MUL_A:   begin u_part_reg <= mul_prod;              state_reg <= MUL_B; end
        MUL_B:   begin u_part_reg <= u_part_reg + mul_prod; state_reg <= MUL_C; end
        MUL_C:   begin v_part_reg <= mul_prod;              state_reg <= MUL_D; end
        MUL_D:   begin v_part_reg <= v_part_reg + mul_prod; state_reg <= LOAD;  end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [2*TEX_LG-1:0] tex_addr_reg;

  // A line load wins over a same-cycle step; an aborted setup never loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_acc_reg    <= '0;
      v_acc_reg    <= '0;
      tex_addr_reg <= '0;
    end else begin
      if (step) tex_addr_reg <= {v_acc_reg[FRAC_W +: TEX_LG], u_acc_reg[FRAC_W +: TEX_LG]};
      if (state_reg == LOAD && !restart) begin
        u_acc_reg <= u_part_reg + x0_fix;
        v_acc_reg <= v_part_reg + y0_fix;
      end else if (step) begin
        u_acc_reg <= u_acc_reg + a_ext;
        v_acc_reg <= v_acc_reg + c_ext;
      end
    end
  end

  logic clamp_hit;
`ifdef MODE7_CLAMP_EN
  // Any set bit above the texture's integer field (incl. sign) means outside the texture.
  logic oob_d1_reg, oob_d2_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      oob_d1_reg <= 1'b0;
      oob_d2_reg <= 1'b0;
    end else begin
      if (step) oob_d1_reg <= (|u_acc_reg[ACC_W-1:FRAC_W+TEX_LG]) || (|v_acc_reg[ACC_W-1:FRAC_W+TEX_LG]);
      oob_d2_reg <= oob_d1_reg;
    end
  end
  assign clamp_hit = oob_d2_reg;
`else
  assign clamp_hit = 1'b0;
`endif

  logic tick_d1_reg, tick_d2_reg, von_d1_reg, von_d2_reg;
  logic [COLOR_W-1:0] rgb_reg;
  logic rgb_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d1_reg   <= 1'b0;
      tick_d2_reg   <= 1'b0;
      von_d1_reg    <= 1'b0;
      von_d2_reg    <= 1'b0;
      rgb_reg       <= '0;
      rgb_valid_reg <= 1'b0;
    end else begin
      tick_d1_reg   <= bus.pixel_tick;
      von_d1_reg    <= bus.video_on;
      tick_d2_reg   <= tick_d1_reg;
      von_d2_reg    <= von_d1_reg;
      rgb_valid_reg <= tick_d2_reg;
      if (tick_d2_reg) begin
        if (!von_d2_reg)    rgb_reg <= '0;
        else if (clamp_hit) rgb_reg <= BACKDROP;
        else                rgb_reg <= bus.tex_data;
      end
    end
  end

  assign bus.tex_addr   = tex_addr_reg;
  assign bus.rgb        = rgb_reg;
  assign bus.rgb_valid  = rgb_valid_reg;
  assign bus.setup_busy = (state_reg != IDLE);
endmodule

// File: tb/tb_mode7_scanline_engine.sv
// Directed + randomized bench for mode7_scanline_engine against a closed-form affine model.
module tb_mode7_scanline_engine;
  localparam int COORD_W = 10;
  localparam int FRAC_W  = 8;
  localparam int MAT_W   = 16;
  localparam int TEX_LG  = 6;
  localparam int COLOR_W = 8;
  localparam int ACC_W   = MAT_W + COORD_W + 2;
  localparam logic [COLOR_W-1:0] BACKDROP = 8'h00;
  localparam longint ACC_MASK = (longint'(1) << ACC_W) - 1;
`ifdef MODE7_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mode7_scanline_engine_if #(.COORD_W(COORD_W), .MAT_W(MAT_W), .TEX_LG(TEX_LG), .COLOR_W(COLOR_W)) bus ();

  mode7_scanline_engine #(
    .COORD_W(COORD_W), .FRAC_W(FRAC_W), .MAT_W(MAT_W), .TEX_LG(TEX_LG), .COLOR_W(COLOR_W),
    .H_ACTIVE(640), .V_ACTIVE(480), .BACKDROP(BACKDROP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [COLOR_W-1:0] rom [4096];
  always @(posedge clk) bus.tex_data <= rom[bus.tex_addr];

  int n_cmp = 0;
  int n_bad = 0;

  longint shadow_m [8];
  longint active_m [8];
  longint u0_m, v0_m, k_m;
  int row_m;
  logic [11:0] exp_addr_m;
  logic [11:0] obs_addr [1024];
  logic [7:0]  obs_rgb  [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint val, input int w);
    longint v;
    v = val & ((longint'(1) << w) - 1);
    if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      shadow_m[i] = (i == 0 || i == 3) ? 256 : 0;
      active_m[i] = shadow_m[i];
    end
    exp_addr_m = '0;
    u0_m = 0; v0_m = 0; k_m = 0; row_m = 0;
  endfunction

  // Start of row y: u0 = A*dx + B*dy + X0*2^F, v0 = C*dx + D*dy + Y0*2^F, all mod 2^ACC_W.
  function automatic void model_row(input int y);
    longint a, b, c, d, h, vv, x0, y0, dx, dy;
    a  = sx(active_m[0], MAT_W);   b  = sx(active_m[1], MAT_W);
    c  = sx(active_m[2], MAT_W);   d  = sx(active_m[3], MAT_W);
    h  = sx(active_m[4], COORD_W); vv = sx(active_m[5], COORD_W);
    x0 = sx(active_m[6], COORD_W); y0 = sx(active_m[7], COORD_W);
    dx = sx(h - x0, COORD_W + 1);
    dy = sx(longint'(y) + vv - y0, COORD_W + 1);
    u0_m = (a * dx + b * dy + x0 * 256) & ACC_MASK;
    v0_m = (c * dx + d * dy + y0 * 256) & ACC_MASK;
    k_m = 0;
    row_m = y;
  endfunction

  // Texel for the k-th visible pixel of the row: start point plus k steps of (A, C).
  function automatic void model_pixel(output logic [11:0] addr, output logic oob);
    longint u, v, ui, vi;
    u = (u0_m + k_m * sx(active_m[0], MAT_W)) & ACC_MASK;
    v = (v0_m + k_m * sx(active_m[2], MAT_W)) & ACC_MASK;
    addr = 12'(((v >> FRAC_W) & 63) * 64 + ((u >> FRAC_W) & 63));
    ui = sx(u, ACC_W) >>> FRAC_W;
    vi = sx(v, ACC_W) >>> FRAC_W;
    oob = (ui < 0) || (ui >= 64) || (vi < 0) || (vi >= 64);
  endfunction

  task automatic pix(input int x, input bit von);
    logic [11:0] ea;
    logic eo;
    logic [7:0] er;
    ea = exp_addr_m;
    eo = 1'b0;
    if (von) begin
      model_pixel(ea, eo);
      k_m++;
      exp_addr_m = ea;
    end
    er = !von ? 8'h00 : ((CLAMP && eo) ? BACKDROP : rom[ea]);
    bus.pixel_tick = 1'b1; bus.video_on = von;
    bus.pixel_x = COORD_W'(x); bus.pixel_y = COORD_W'(row_m);
    @(posedge clk); #1;
    bus.pixel_tick = 1'b0; bus.video_on = 1'b0;
    chk("tex_addr", 32'(bus.tex_addr), 32'(ea));
    if (von) obs_addr[x] = bus.tex_addr;
    @(posedge clk); #1;
    chk("rgb_valid_t2", 32'(bus.rgb_valid), 32'd0);
    @(posedge clk); #1;
    chk("rgb_valid_t3", 32'(bus.rgb_valid), 32'd1);
    chk("rgb", 32'(bus.rgb), 32'(er));
    if (von) obs_rgb[x] = bus.rgb;
    @(posedge clk); #1;
    chk("rgb_valid_t4", 32'(bus.rgb_valid), 32'd0);
  endtask

  task automatic run_row(input int nx, input int blank_at);
    for (int x = 0; x < nx; x++) begin
      if (x == blank_at) pix(1000, 1'b0);
      pix(x, 1'b1);
    end
    $display("row %0d: %0d pixels, first tex_addr %03h", row_m, nx, obs_addr[0]);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (bus.setup_busy === 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk(tag, 32'(n), 32'd5);
  endtask

  task automatic cfg_write(input int addr, input longint data);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_wdata = MAT_W'(data);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    shadow_m[addr] = data & 16'hFFFF;
  endtask

  task automatic frame(input bit we, input int addr, input longint data);
    bus.frame_start = 1'b1;
    if (we) begin bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_wdata = MAT_W'(data); end
    @(posedge clk); #1;
    bus.frame_start = 1'b0; bus.cfg_we = 1'b0;
    for (int i = 0; i < 8; i++) active_m[i] = shadow_m[i];
    if (we) shadow_m[addr] = data & 16'hFFFF;
    model_row(0);
    wait_busy("frame_setup_busy");
  endtask

  task automatic line_trigger();
    bus.pixel_tick = 1'b1; bus.video_on = 1'b0;
    bus.pixel_x = COORD_W'(640); bus.pixel_y = COORD_W'(row_m);
    @(posedge clk); #1;
    bus.pixel_tick = 1'b0;
  endtask

  task automatic next_row();
    line_trigger();
    model_row(row_m + 1);
    wait_busy("line_setup_busy");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] a6;
    logic eo6;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    bus.pixel_tick = 0; bus.video_on = 0; bus.pixel_x = '0; bus.pixel_y = '0;
    bus.frame_start = 0; bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tex_addr", 32'(bus.tex_addr), 32'd0);
    chk("rst_rgb", 32'(bus.rgb), 32'd0);
    chk("rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
    chk("rst_setup_busy", 32'(bus.setup_busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: identity mapping, wrap at 64
    frame(1'b0, 0, 0);
    run_row(72, -1);
    chk("c1_x5", 32'(obs_addr[5]), 32'h005);
    chk("c1_x70", 32'(obs_addr[70]), 32'h006);
    next_row();
    run_row(8, 4);
    chk("c1_row1_x0", 32'(obs_addr[0]), 32'h040);

    // 2: half-scale
    cfg_write(0, 16'h0080);
    cfg_write(3, 16'h0080);
    frame(1'b0, 0, 0);
    run_row(12, -1);
    chk("c2_u_x10", 32'(obs_addr[10][5:0]), 32'd5);
    next_row(); run_row(2, -1);
    next_row(); run_row(2, -1);
    next_row(); run_row(4, -1);
    chk("c2_v_row3", 32'(obs_addr[0][11:6]), 32'd1);

    // 3: mid-frame write stays in shadow until frame_start
    cfg_write(0, 16'h0200);
    next_row(); run_row(6, -1);
    chk("c3_same_frame", 32'(obs_addr[4][5:0]), 32'd2);
    frame(1'b0, 0, 0);
    run_row(4, -1);
    chk("c3_next_frame", 32'(obs_addr[3][5:0]), 32'd6);

    // 4: negative scroll
    cfg_write(0, 16'h0100);
    cfg_write(3, 16'h0100);
    cfg_write(4, 16'h03FD);
    frame(1'b0, 0, 0);
    run_row(6, -1);
    chk("c4_x0", 32'(obs_addr[0]), 32'h03D);
    if (CLAMP) begin
      for (int x = 0; x < 3; x++) chk("c4_backdrop", 32'(obs_rgb[x]), 32'(BACKDROP));
    end

    // 5: frame_start during MUL_C restarts the setup
    cfg_write(4, 0);
    line_trigger();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("c5_busy_mid", 32'(bus.setup_busy), 32'd1);
    frame(1'b0, 0, 0);
    run_row(8, -1);
    chk("c5_x5", 32'(obs_addr[5]), 32'h005);

    // 6: reset mid-line
    cfg_write(0, 16'h0300);
    frame(1'b0, 0, 0);
    run_row(3, -1);
    model_pixel(a6, eo6);
    rom[a6] = 8'hA5;
    bus.pixel_tick = 1'b1; bus.video_on = 1'b1; bus.pixel_x = 10'd3; bus.pixel_y = '0;
    @(posedge clk); #1;
    bus.video_on = 1'b0; bus.pixel_x = 10'd640;
    @(posedge clk); #1;
    bus.pixel_tick = 1'b0;
    chk("c6_busy_before", 32'(bus.setup_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("c6_rgb", 32'(bus.rgb), 32'd0);
    chk("c6_rgb_valid", 32'(bus.rgb_valid), 32'd0);
    chk("c6_setup_busy", 32'(bus.setup_busy), 32'd0);
    chk("c6_tex_addr", 32'(bus.tex_addr), 32'd0);
    model_reset();
    @(posedge clk); #1;
    frame(1'b0, 0, 0);
    run_row(8, -1);
    chk("c6_identity_x5", 32'(obs_addr[5]), 32'h005);

    // randomized frames against the model
    for (int f = 0; f < 4; f++) begin
      int nrows;
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 1) == 1 || f == 0) begin
          if (r < 4) cfg_write(r, (r == 0 || r == 3) ? longint'($urandom_range(0, 1024)) - 512
                                                     : longint'($urandom_range(0, 256)) - 128);
          else       cfg_write(r, longint'($urandom_range(0, 1023)));
        end
      end
      frame(1'b1, int'($urandom_range(0, 7)), longint'($urandom_range(0, 255)));
      nrows = int'($urandom_range(2, 3));
      for (int r = 0; r < nrows; r++) begin
        int nx;
        if (r > 0) next_row();
        nx = int'($urandom_range(5, 40));
        run_row(nx, int'($urandom_range(0, nx)) - 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
